led_frame_loader: RTL and testbench
===================================

# led_frame_loader

Serial frame loader for the 5-column × 10-row LED matrix. It deserialises a 50-bit frame from a strobed single-bit input into a private load buffer. It then hands the complete frame to the column scanner only at a scan boundary, so a displayed frame never tears. It is the writer side of the scanner's 50-bit pixel bus: the scanner reads `frame_out` column by column and reports end-of-sweep on `scan_done`.

## Interface
- `COLS`, default 5, number of matrix columns (ground lines).
- `ROWS`, default 10, LEDs per column.
- `TIMEOUT`, default 1000, maximum idle cycles between strobes inside a frame before the load aborts; minimum 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock, `clk`.
- `ser_sync`  in  1  start-of-frame pulse, sampled synchronously.
- `ser_strobe`  in  1  qualifies `ser_data` for one cycle.
- `ser_data`  in  1  pixel bit; 1 = LED on.
- `scan_done`  in  1  one-cycle pulse from the scanner on the last column of a sweep.
- `frame_out`  out  COLS*ROWS (50)  committed frame. Bit index k = col*ROWS + row.
- `frame_valid`  out  1  high once any frame has been committed; stays high until reset.
- `frame_swapped`  out  1  one-cycle pulse on each commit.
- `err_short`  out  1  one-cycle pulse when a load is abandoned: resync mid-load, or timeout.
- `err_overrun`  out  1  one-cycle pulse when a pending frame is discarded by a new `ser_sync`.
- `busy`  out  1  high in LOAD or PEND.

## Operation
- Reset values of all outputs are 0: `frame_out`, `frame_valid`, `frame_swapped`, `err_short`, `err_overrun`, `busy`. Reset also clears the load buffer, bit counter and idle counter, and sets the state to IDLE.
- The state machine has three states: IDLE, LOAD and PEND.
- **IDLE**
  - `ser_strobe` and `scan_done` are ignored.
  - `ser_sync` moves the state to LOAD, with bit counter = 0 and idle counter = 0.
- **LOAD**
  - Each cycle with `ser_strobe`=1 writes `ser_data` into load_buf[bit_cnt], increments bit_cnt and clears the idle counter. The first bit received is bit 0 (column 0, row 0).
  - The strobe that writes bit 49 moves the state to PEND.
  - `ser_sync` in LOAD restarts the load: bit_cnt = 0, `err_short` pulses, and the state stays LOAD. The load buffer is not cleared, because every bit is rewritten before it is used.
  - `ser_sync` and `ser_strobe` in the same cycle: sync wins and the strobe is dropped.
  - The idle counter increments on every non-strobe cycle. When it reaches TIMEOUT, the state goes to IDLE and `err_short` pulses.
  - `scan_done` is ignored.
- **PEND**
  - `ser_strobe` is ignored.
  - On `scan_done`=1: `frame_out` <= load_buf, `frame_valid` <= 1, `frame_swapped` pulses, and the state goes to IDLE.
  - On `ser_sync` without `scan_done`: the pending frame is dropped, `err_overrun` pulses, and the state goes to LOAD with bit_cnt = 0.
  - On `scan_done` and `ser_sync` in the same cycle: the commit happens first, then the state goes to LOAD with bit_cnt = 0. `frame_swapped` pulses and `err_overrun` does not.
- `busy` = (state ≠ IDLE), registered with the state.
- The bit counter is 6 bits wide. It never wraps, because it leaves LOAD at 50.
- The `frame_out` register is written only on a commit. It holds its value through every other event, including errors.

## Timing
- All outputs are registered. None has a combinational path from an input.
- Bit capture: `ser_data` sampled on edge E is visible in load_buf after E.
- The last strobe on edge E makes the state PEND after E.
- The earliest commit is the next edge (E+1) if `scan_done` is high there.
- Commit latency: `scan_done` sampled on edge C means `frame_out`, `frame_valid` and `frame_swapped` update after C. The scanner shows the new frame from the following sweep.
- Minimum frame time is 51 cycles: a 1-cycle sync plus 50 back-to-back strobes.
- Error and commit pulses are exactly one cycle wide.
- Reset asserted mid-operation returns the block to IDLE immediately and clears `frame_out` asynchronously, which blanks the display.

## Test plan
- **Basic load:** reset, sync, 50 strobes with a pattern setting only bit k = 3*k mod 50 (see note below), then a `scan_done` pulse.
  - Required: `frame_out` equals the pattern, `frame_valid`=1, and `frame_swapped` pulses 1 cycle after the `scan_done` edge.
  - Note: the pattern formula needs confirming. 3*k mod 50 equals k only for k = 0 and k = 25, so as written it sets only bits 0 and 25. It is probably meant to be a scattered pattern such as "bit k set iff (3*k mod 50) is odd".
- **Hold until boundary:** load 0x3FFFFFFFFFFFF (all 50 bits set), then keep `scan_done` low for 500 cycles.
  - Required: `frame_out` stays 0 and `busy`=1 throughout.
  - Then pulse `scan_done`: required `frame_out` = all ones and `busy`=0.
- **Resync mid-load:** sync, 20 strobes of 1, sync, then 50 strobes of 0, then `scan_done`.
  - Required: `err_short` pulses once and `frame_out` = 0 (no stale ones).
- **Overrun and simultaneous events:**
  - Fill a frame, then sync while in PEND. Required: `err_overrun` pulses.
  - Load a second frame of all ones, then assert `scan_done` together with a new sync. Required: commit of all ones, no `err_overrun`, and `busy` stays 1 in LOAD.
- **Timeout:** sync, 10 strobes, then no strobe for TIMEOUT cycles. Required: `err_short` pulses on the TIMEOUT-th idle cycle and the state returns to IDLE; a later `scan_done` leaves `frame_out` unchanged.
- **Async reset:** assert `rst_n`=0 mid-LOAD between clock edges. Required: every output is 0 immediately. After release, strobes without a sync are ignored.

Source files
------------

// File: rtl/led_frame_loader.sv
// Serial frame loader for the LED matrix: deserialises a strobed bitstream into a
// private buffer and commits it to the column scanner only on an end-of-sweep pulse.
module led_frame_loader #(
  parameter int COLS    = 5,
  parameter int ROWS    = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ser_sync_i,
  input  logic                 ser_strobe_i,
  input  logic                 ser_data_i,
  input  logic                 scan_done_i,
  output logic [COLS*ROWS-1:0] frame_out_o,
  output logic                 frame_valid_o,
  output logic                 frame_swapped_o,
  output logic                 err_short_o,
  output logic                 err_overrun_o,
  output logic                 busy_o
);
  localparam int N  = COLS * ROWS;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PEND} state_e;

  state_e          state_q;
  logic [N-1:0]    load_buf_q;
  logic [CW-1:0]   bit_cnt_q;
  logic [IW-1:0]   idle_q;
  logic [N-1:0]    frame_out_q;
  logic            frame_valid_q;
  logic            frame_swapped_q;
  logic            err_short_q;
  logic            err_overrun_q;
  logic            busy_q;

  logic [CW-1:0]   bit_cnt_d;
  logic [IW-1:0]   idle_d;
  logic            last_bit;
  logic            timeout_hit;

  always_comb begin
    bit_cnt_d   = bit_cnt_q + 1'b1;
    idle_d      = idle_q + 1'b1;
    last_bit    = (bit_cnt_q == CW'(N - 1));
    timeout_hit = (idle_d == IW'(TIMEOUT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      load_buf_q      <= '0;
      bit_cnt_q       <= '0;
      idle_q          <= '0;
      frame_out_q     <= '0;
      frame_valid_q   <= 1'b0;
      frame_swapped_q <= 1'b0;
      err_short_q     <= 1'b0;
      err_overrun_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      frame_swapped_q <= 1'b0;
      err_short_q     <= 1'b0;
      err_overrun_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ser_sync_i) begin
            state_q   <= S_LOAD;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            idle_q    <= '0;
          end
        end
        S_LOAD: begin
          // A resync leaves load_buf_q alone: every bit is rewritten before commit.
          if (ser_sync_i) begin
            bit_cnt_q   <= '0;
            idle_q      <= '0;
            err_short_q <= 1'b1;
          end else if (ser_strobe_i) begin
            load_buf_q[bit_cnt_q] <= ser_data_i;
            bit_cnt_q             <= bit_cnt_d;
            idle_q                <= '0;
            if (last_bit) state_q <= S_PEND;
          end else if (timeout_hit) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            idle_q      <= '0;
            err_short_q <= 1'b1;
          end else begin
            idle_q <= idle_d;
          end
        end
        S_PEND: begin
          // Commit wins over a coincident sync; the new load then starts cleanly.
          if (scan_done_i) begin
            frame_out_q     <= load_buf_q;
            frame_valid_q   <= 1'b1;
            frame_swapped_q <= 1'b1;
            if (ser_sync_i) begin
              state_q   <= S_LOAD;
              bit_cnt_q <= '0;
              idle_q    <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (ser_sync_i) begin
            state_q       <= S_LOAD;
            bit_cnt_q     <= '0;
            idle_q        <= '0;
            err_overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign frame_out_o     = frame_out_q;
  assign frame_valid_o   = frame_valid_q;
  assign frame_swapped_o = frame_swapped_q;
  assign err_short_o     = err_short_q;
  assign err_overrun_o   = err_overrun_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_led_frame_loader.sv
// Bench for led_frame_loader: queue-based frame model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_led_frame_loader;
  localparam int COLS = 5;
  localparam int ROWS = 10;
  localparam int N    = COLS * ROWS;
  localparam int TO   = 64;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sync = 1'b0, strobe = 1'b0, data = 1'b0, sd = 1'b0;
  logic [N-1:0] frame_out;
  logic frame_valid, swapped, err_short, err_overrun, busy;

  int vectors = 0, miscompares = 0, shown = 0;

  always #5 clk = ~clk;

  led_frame_loader #(.COLS(COLS), .ROWS(ROWS), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ser_sync_i(sync), .ser_strobe_i(strobe), .ser_data_i(data), .scan_done_i(sd),
    .frame_out_o(frame_out), .frame_valid_o(frame_valid), .frame_swapped_o(swapped),
    .err_short_o(err_short), .err_overrun_o(err_overrun), .busy_o(busy)
  );

  // Model: bits of the current load in a queue, plus an optional pending frame.
  bit           mq[$];
  bit           m_loading, m_pending, m_valid, m_sw, m_es, m_eo;
  int           m_idle;
  logic [N-1:0] m_pend_frame, m_frame;

  function automatic void m_start();
    mq.delete();
    m_idle    = 0;
    m_loading = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_loading = 0; m_pending = 0; m_valid = 0;
      m_sw = 0; m_es = 0; m_eo = 0; m_idle = 0;
      m_pend_frame = '0; m_frame = '0;
    end else begin
      m_sw = 0; m_es = 0; m_eo = 0;
      if (m_pending) begin
        if (sd) begin
          m_frame = m_pend_frame; m_valid = 1; m_sw = 1; m_pending = 0;
          if (sync) m_start();
        end else if (sync) begin
          m_eo = 1; m_pending = 0; m_start();
        end
      end else if (m_loading) begin
        if (sync) begin
          m_es = 1; m_start();
        end else if (strobe) begin
          mq.push_back(data);
          m_idle = 0;
          if (mq.size() == N) begin
            for (int k = 0; k < N; k++) m_pend_frame[k] = mq[k];
            m_pending = 1; m_loading = 0;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_loading = 0; m_es = 1; end
        end
      end else if (sync) begin
        m_start();
      end
    end
  end

  task automatic cmp_cycle();
    bit m_busy;
    m_busy = m_loading || m_pending;
    vectors++;
    if (frame_out !== m_frame || frame_valid !== m_valid || swapped !== m_sw ||
        err_short !== m_es || err_overrun !== m_eo || busy !== m_busy) begin
      miscompares++;
      if (shown < 20)
        $display("FAIL cycle t=%0t: got fo=%h v=%b sw=%b es=%b eo=%b busy=%b, expected fo=%h v=%b sw=%b es=%b eo=%b busy=%b",
                 $time, frame_out, frame_valid, swapped, err_short, err_overrun, busy,
                 m_frame, m_valid, m_sw, m_es, m_eo, m_busy);
      shown++;
    end
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, let the rising edge consume them, check at the falling edge.
  task automatic cyc(input logic s, input logic st, input logic d, input logic done);
    sync = s; strobe = st; data = d; sd = done;
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic load_frame(input logic [N-1:0] f);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < N; k++) cyc(0, 1, f[k], 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  logic [N-1:0] pat, ones, rnd;
  int           pct;

  initial begin
    ones = '1;
    for (int k = 0; k < N; k++) pat[k] = ((3 * k) % 50) % 2;

    @(negedge clk);
    cmp_cycle();
    chk("reset frame_out", frame_out, '0);
    chk1("reset frame_valid", frame_valid, 1'b0);
    chk1("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Basic load with a scattered pattern
    load_frame(pat);
    chk1("pend busy", busy, 1'b1);
    chk("pend frame_out held", frame_out, '0);
    cyc(0, 0, 0, 1);
    chk("basic frame_out", frame_out, 50'h2_AAAA_AAAA_AAAA);
    chk("model basic frame", m_frame, 50'h2_AAAA_AAAA_AAAA);
    chk1("basic frame_valid", frame_valid, 1'b1);
    chk1("basic swapped", swapped, 1'b1);
    idle(1);
    chk1("swapped one cycle", swapped, 1'b0);

    // Hold until scan boundary
    do_reset();
    load_frame(ones);
    for (int i = 0; i < 500; i++) cyc(0, $urandom_range(0, 1), 1'b1, 0);
    chk("hold frame_out", frame_out, '0);
    chk1("hold busy", busy, 1'b1);
    cyc(0, 0, 0, 1);
    chk("hold commit", frame_out, 50'h3_FFFF_FFFF_FFFF);
    chk1("hold busy after", busy, 1'b0);

    // Resync mid-load
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    chk1("resync err_short", err_short, 1'b1);
    for (int k = 0; k < N; k++) cyc(0, 1, 0, 0);
    chk1("resync no extra err", err_short, 1'b0);
    cyc(0, 0, 0, 1);
    chk("resync frame_out", frame_out, '0);

    // Overrun, then coincident commit + sync
    rnd = {$urandom, $urandom};
    load_frame(rnd);
    cyc(1, 0, 0, 0);
    chk1("overrun pulse", err_overrun, 1'b1);
    chk1("overrun busy", busy, 1'b1);
    for (int k = 0; k < N; k++) cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 1);
    chk("coincident commit", frame_out, 50'h3_FFFF_FFFF_FFFF);
    chk1("coincident swapped", swapped, 1'b1);
    chk1("coincident no overrun", err_overrun, 1'b0);
    chk1("coincident busy", busy, 1'b1);

    // Timeout (the sync here also resyncs the load begun above)
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 1, 0, 0);
    idle(TO - 1);
    chk1("timeout not yet", err_short, 1'b0);
    chk1("timeout busy before", busy, 1'b1);
    idle(1);
    chk1("timeout err_short", err_short, 1'b1);
    chk1("timeout busy after", busy, 1'b0);
    cyc(0, 0, 0, 1);
    chk("timeout frame held", frame_out, ones);
    chk1("timeout no swap", swapped, 1'b0);

    // Asynchronous reset mid-load
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async frame_out", frame_out, '0);
    chk1("async frame_valid", frame_valid, 1'b0);
    chk1("async swapped", swapped, 1'b0);
    chk1("async err_short", err_short, 1'b0);
    chk1("async err_overrun", err_overrun, 1'b0);
    chk1("async busy", busy, 1'b0);
    @(negedge clk);
    cmp_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cyc(0, 1, 1, 0);
    chk1("post reset busy", busy, 1'b0);
    chk1("post reset valid", frame_valid, 1'b0);

    // Randomized traffic with varying strobe density
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0: pct = 100;
        1: pct = 70;
        2: pct = 30;
        default: pct = 1;
      endcase
      for (int i = 0; i < 80; i++) begin
        logic s;
        if (!m_loading && !m_pending) s = ($urandom_range(0, 99) < 20);
        else s = ($urandom_range(0, 199) == 0);
        cyc(s, $urandom_range(0, 99) < pct, $urandom_range(0, 1), $urandom_range(0, 99) < 6);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
